rng_stream_checker: RTL and testbench
=====================================

# rng_stream_checker

Receive-side checker for the 32-bit linear-congruential random stream produced by the team's `random_generator`. It samples each valid word and locks onto the sequence from the first word. It then predicts every following word with the same recurrence, next = cur × 1103515245 + 12345 mod 2^DATA_WIDTH, and flags and counts mismatches. It sits at the consumer end of any link or FIFO carrying the random stream and gives a pass/fail signal for datapath integrity tests.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the random word; the recurrence wraps modulo 2^DATA_WIDTH.
- CNT_WIDTH, 16, width of the sample and error counters.
- MISS_LIMIT, 4, consecutive mismatches that force a re-hunt; used only when resync is compiled in; legal range ≥1.

Ports:
- clk  in  1  the single clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  rnd_in carries a valid word this cycle.
- rnd_in  in  DATA_WIDTH  received random word.
- clear  in  1  synchronous; zeroes both counters and returns to HUNT.
- locked  out  1  high while in LOCKED.
- error  out  1  one-cycle pulse on a mismatching sample.
- sample_count  out  CNT_WIDTH  samples checked while LOCKED; saturates.
- err_count  out  CNT_WIDTH  mismatches; saturates.

## Operation
- State machine with two states, HUNT and LOCKED. Reset state is HUNT.
- HUNT, enable=1:
  - expected ← step(rnd_in); go to LOCKED.
  - The sample is not counted and no error is raised.
- LOCKED, enable=1, match (rnd_in == expected):
  - expected ← step(rnd_in); sample_count +1; miss run ← 0.
- LOCKED, enable=1, mismatch:
  - error pulse; err_count +1; sample_count +1; miss run +1.
  - expected ← step(expected), so a single corrupted word costs exactly one error.
- enable=0: no state, counter or expected change; error is low.
- step() is the full-width product truncated to DATA_WIDTH bits plus 12345, also truncated. There is no carry out.
- Counters saturate at all-ones and never wrap.
- clear has priority over enable in the same cycle. It acts as follows:
  - Counters go to 0, state goes to HUNT, miss run goes to 0, error goes low.
  - The sample presented in that cycle is ignored.
- Reset mid-stream: all state is lost immediately. The checker re-locks on the next valid word.

## Timing
- All outputs are registered.
- A sample presented at edge N produces error, counter updates and locked at edge N, visible during cycle N+1. Latency is one cycle.
- error is high for exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back pulses.
- Reset values: locked=0, error=0, sample_count=0, err_count=0. The internal expected register resets to 0 and the miss run resets to 0.
- The first valid word after reset or clear only seeds the checker. locked rises in the following cycle.

## Configuration
- Macro: RNG_STREAM_CHECKER_RESYNC_EN.
- Defined:
  - In LOCKED, a mismatch that brings the miss run to MISS_LIMIT still pulses error and counts.
  - The state then returns to HUNT and the miss run resets.
  - The next valid word re-seeds the checker.
- Undefined:
  - The checker never leaves LOCKED except by rst_n or clear.
  - The miss-run counter is not built.

## Structure
- Shared package rng_pkg holds:
  - LCG_MULT = 1103515245, LCG_INC = 12345, LCG_SEED = 123456.
  - The checker state enum {HUNT, LOCKED}.
  - `random_generator` is to adopt the same constants.
- One sub-module, lcg_step. It is combinational and parameterized by DATA_WIDTH, computing out = in × LCG_MULT + LCG_INC truncated. It is instantiated twice: once on rnd_in and once on expected. The generator can reuse it.

## Test plan
- Seed and lock:
  - Stimulus: reset, then a valid 123456 followed by 3510437241.
  - Required response: locked=1 after the first word; no error; sample_count=1.
- Long run:
  - Stimulus: drive the sequence from a `random_generator` instance for 1000 enables with random enable gaps.
  - Required response: err_count=0 and sample_count=999.
- Single-word corruption:
  - Stimulus: while locked, flip bit 0 of one word.
  - Required response: exactly one error pulse, err_count=1, and the following words match again.
- Resync (macro defined, MISS_LIMIT=4):
  - Stimulus: switch to an unrelated valid LCG sequence.
  - Required response: four error pulses, then locked=0 for one sample, then locked=1 and no further errors.
- Saturation and clear:
  - Stimulus: CNT_WIDTH=4 with 20 corrupted words.
  - Required response: err_count stays at 15. A following clear together with enable zeroes the counters, ignores that sample, and drops locked.
- Asynchronous reset:
  - Stimulus: assert rst_n low between clock edges while locked.
  - Required response: all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared constants and types for the LCG random stream generator/checker.
package rng_pkg;

    localparam logic [31:0] LCG_MULT = 32'd1103515245;
    localparam logic [31:0] LCG_INC  = 32'd12345;
    localparam logic [31:0] LCG_SEED = 32'd123456;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

endpackage

// File: rtl/lcg_step.sv
// One LCG step: dout = din * LCG_MULT + LCG_INC, truncated to DATA_WIDTH.
module lcg_step
    import rng_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam logic [DATA_WIDTH-1:0] MULT_W = DATA_WIDTH'(LCG_MULT);
    localparam logic [DATA_WIDTH-1:0] INC_W  = DATA_WIDTH'(LCG_INC);

    assign dout = din * MULT_W + INC_W;

endmodule

// File: rtl/rng_stream_checker.sv
// Locks onto an LCG stream and counts mismatching words.
// Optional re-hunt after MISS_LIMIT misses: RNG_STREAM_CHECKER_RESYNC_EN.
module rng_stream_checker
    import rng_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int MISS_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rnd_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    chk_state_t            state;
    logic [DATA_WIDTH-1:0] expected;
    logic [DATA_WIDTH-1:0] step_rnd;
    logic [DATA_WIDTH-1:0] step_exp;
    logic                  match;

    lcg_step #(.DATA_WIDTH(DATA_WIDTH)) u_step_rnd (
        .din  (rnd_in),
        .dout (step_rnd)
    );

    lcg_step #(.DATA_WIDTH(DATA_WIDTH)) u_step_exp (
        .din  (expected),
        .dout (step_exp)
    );

    assign match  = (rnd_in == expected);
    assign locked = (state == LOCKED);

`ifdef RNG_STREAM_CHECKER_RESYNC_EN
    localparam int MW = $clog2(MISS_LIMIT + 1);
    logic [MW-1:0] miss_run;
    logic          miss_hit;
    assign miss_hit = (miss_run == MW'(MISS_LIMIT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            expected     <= '0;
            error        <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
`ifdef RNG_STREAM_CHECKER_RESYNC_EN
            miss_run     <= '0;
`endif
        end else begin
            error <= 1'b0;
            if (clear) begin
                state        <= HUNT;
                sample_count <= '0;
                err_count    <= '0;
`ifdef RNG_STREAM_CHECKER_RESYNC_EN
                miss_run     <= '0;
`endif
            end else if (enable) begin
                case (state)
                    HUNT: begin
                        expected <= step_rnd;
                        state    <= LOCKED;
                    end
                    LOCKED: begin
                        if (sample_count != '1)
                            sample_count <= sample_count + 1'b1;
                        if (match) begin
                            expected <= step_rnd;
`ifdef RNG_STREAM_CHECKER_RESYNC_EN
                            miss_run <= '0;
`endif
                        end else begin
                            // Advance from the prediction so one bad word costs one error
                            expected <= step_exp;
                            error    <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
`ifdef RNG_STREAM_CHECKER_RESYNC_EN
                            if (miss_hit) begin
                                miss_run <= '0;
                                state    <= HUNT;
                            end else begin
                                miss_run <= miss_run + 1'b1;
                            end
`endif
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rng_stream_checker.sv
// Directed self-checking bench for rng_stream_checker.
module tb_rng_stream_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] rnd_in;
    logic        clear;

    logic        locked;
    logic        error;
    logic [15:0] sample_count;
    logic [15:0] err_count;

    logic        s_locked;
    logic        s_error;
    logic [3:0]  s_sample_count;
    logic [3:0]  s_err_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur;

    rng_stream_checker #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16),
        .MISS_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rnd_in       (rnd_in),
        .clear        (clear),
        .locked       (locked),
        .error        (error),
        .sample_count (sample_count),
        .err_count    (err_count)
    );

    rng_stream_checker #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (4),
        .MISS_LIMIT (64)
    ) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rnd_in       (rnd_in),
        .clear        (clear),
        .locked       (s_locked),
        .error        (s_error),
        .sample_count (s_sample_count),
        .err_count    (s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'd1103515245 + 32'd12345;
    endfunction

    // Present one word at the falling edge; return after the next falling edge.
    task automatic drive(input logic [31:0] w);
        enable = 1'b1;
        rnd_in = w;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        rnd_in = '0;
        idle(2);
        checks++;
        if ({locked, error, sample_count, err_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%0b e=%0b s=%0d ec=%0d want all 0",
                     locked, error, sample_count, err_count);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_seed_lock();
        drive(32'd123456);
        checks++;
        if (locked !== 1'b1 || error !== 1'b0 || sample_count !== 16'd0) begin
            errors++;
            $display("FAIL seed: got l=%0b e=%0b s=%0d want l=1 e=0 s=0",
                     locked, error, sample_count);
        end
        drive(32'd3510437241);
        checks++;
        if (error !== 1'b0 || sample_count !== 16'd1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL lock_second: got e=%0b s=%0d ec=%0d want e=0 s=1 ec=0",
                     error, sample_count, err_count);
        end
        cur = 32'd3510437241;
    endtask

    task automatic test_long_run();
        int seen_err;
        seen_err = 0;
        do_clear();
        for (int i = 0; i < 1000; i++) begin
            cur = lcg(cur);
            drive(cur);
            if (error) seen_err++;
            idle($urandom_range(0, 3));
        end
        checks++;
        if (err_count !== 16'd0 || seen_err != 0) begin
            errors++;
            $display("FAIL long_err: got ec=%0d pulses=%0d want 0", err_count, seen_err);
        end
        checks++;
        if (sample_count !== 16'd999 || locked !== 1'b1) begin
            errors++;
            $display("FAIL long_samples: got s=%0d l=%0b want s=999 l=1",
                     sample_count, locked);
        end
    endtask

    task automatic test_corruption();
        do_clear();
        cur = lcg(cur);
        drive(cur);
        for (int i = 0; i < 3; i++) begin
            cur = lcg(cur);
            drive(cur);
        end
        cur = lcg(cur);
        drive(cur ^ 32'd1);
        checks++;
        if (error !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL corrupt_pulse: got e=%0b ec=%0d want e=1 ec=1", error, err_count);
        end
        for (int i = 0; i < 3; i++) begin
            cur = lcg(cur);
            drive(cur);
            checks++;
            if (error !== 1'b0) begin
                errors++;
                $display("FAIL corrupt_recover%0d: got e=%0b want e=0", i, error);
            end
        end
        checks++;
        if (err_count !== 16'd1 || sample_count !== 16'd7) begin
            errors++;
            $display("FAIL corrupt_counts: got ec=%0d s=%0d want ec=1 s=7",
                     err_count, sample_count);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        cur = lcg(cur);
        drive(cur ^ 32'h8000_0000);
        if (error) pulses++;
        cur = lcg(cur);
        drive(cur ^ 32'h0000_0100);
        if (error) pulses++;
        checks++;
        if (pulses != 2 || err_count !== 16'd3) begin
            errors++;
            $display("FAIL b2b_errors: got pulses=%0d ec=%0d want 2 and 3", pulses, err_count);
        end
        cur = lcg(cur);
        drive(cur);
        checks++;
        if (error !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL b2b_recover: got e=%0b l=%0b want e=0 l=1", error, locked);
        end
    endtask

`ifdef RNG_STREAM_CHECKER_RESYNC_EN
    task automatic test_resync();
        logic [31:0] b;
        int pulses;
        pulses = 0;
        do_clear();
        cur = lcg(cur);
        drive(cur);
        b = 32'd777;
        for (int i = 0; i < 4; i++) begin
            b = lcg(b);
            drive(b);
            if (error) pulses++;
        end
        checks++;
        if (pulses != 4 || locked !== 1'b0) begin
            errors++;
            $display("FAIL resync_drop: got pulses=%0d l=%0b want 4 and l=0", pulses, locked);
        end
        b = lcg(b);
        drive(b);
        checks++;
        if (locked !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL resync_seed: got l=%0b e=%0b want l=1 e=0", locked, error);
        end
        b = lcg(b);
        drive(b);
        checks++;
        if (error !== 1'b0 || err_count !== 16'd4) begin
            errors++;
            $display("FAIL resync_match: got e=%0b ec=%0d want e=0 ec=4", error, err_count);
        end
        cur = b;
    endtask
`endif

    task automatic test_saturation_clear();
        do_clear();
        cur = lcg(cur);
        drive(cur);
        for (int i = 0; i < 20; i++) begin
            cur = lcg(cur);
            drive(cur ^ 32'd1);
        end
        checks++;
        if (s_err_count !== 4'd15 || s_sample_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_counts: got ec=%0d s=%0d want 15 and 15",
                     s_err_count, s_sample_count);
        end
`ifndef RNG_STREAM_CHECKER_RESYNC_EN
        checks++;
        if (err_count !== 16'd20) begin
            errors++;
            $display("FAIL wide_counts: got ec=%0d want 20", err_count);
        end
`endif
        clear = 1'b1;
        cur = lcg(cur);
        drive(cur);
        clear = 1'b0;
        checks++;
        if ({s_locked, s_error, s_sample_count, s_err_count} !== 10'd0 ||
            {locked, error, sample_count, err_count} !== 34'd0) begin
            errors++;
            $display("FAIL clear_enable: got l=%0b e=%0b s=%0d ec=%0d want all 0",
                     s_locked, s_error, s_sample_count, s_err_count);
        end
        cur = 32'hDEAD_BEEF;
        drive(cur);
        checks++;
        if (s_locked !== 1'b1 || s_sample_count !== 4'd0 || s_error !== 1'b0) begin
            errors++;
            $display("FAIL clear_reseed: got l=%0b s=%0d e=%0b want l=1 s=0 e=0",
                     s_locked, s_sample_count, s_error);
        end
    endtask

    task automatic test_async_reset();
        cur = lcg(cur);
        drive(cur);
        cur = lcg(cur);
        enable = 1'b1;
        rnd_in = cur ^ 32'd4;
        @(posedge clk);
        #2;
        enable = 1'b0;
        checks++;
        if (locked !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got l=%0b e=%0b want l=1 e=1", locked, error);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, error, sample_count, err_count} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: got l=%0b e=%0b s=%0d ec=%0d want all 0",
                     locked, error, sample_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        drive(32'd123456);
        drive(32'd3510437241);
        checks++;
        if (locked !== 1'b1 || error !== 1'b0 || sample_count !== 16'd1) begin
            errors++;
            $display("FAIL relock: got l=%0b e=%0b s=%0d want l=1 e=0 s=1",
                     locked, error, sample_count);
        end
    endtask

    initial begin
        test_reset();
        test_seed_lock();
        test_long_run();
        test_corruption();
        test_back_to_back();
`ifdef RNG_STREAM_CHECKER_RESYNC_EN
        test_resync();
`endif
        test_saturation_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
